// File: rtl/type_rule_cfg_ctrl_pkg.sv
// Shared types and constants for the parser rule-table configuration path.
package type_rule_cfg_ctrl_pkg;

  // One type-lookup rule as stored in each parser stage's table.
  // typeRule_valid sits at the MSB so a cleared (all-zero) entry is invalid.
  typedef struct packed {
    logic        typeRule_valid;
    logic [5:0]  typeRule_offset;
    logic [15:0] typeRule_mask;
    logic [15:0] typeRule_value;
    logic [7:0]  typeRule_type_id;
  } type_rule_t;

  localparam int RULE_NUM   = 16;
  localparam int RULE_BITS  = $bits(type_rule_t);
  localparam int RULE_WORDS = (RULE_BITS + 31) / 32;
  localparam int WCNT_W     = (RULE_WORDS > 1) ? $clog2(RULE_WORDS) : 1;

  // Header word layout
  localparam int HDR_OP_LSB    = 28;
  localparam int HDR_OP_W      = 4;
  localparam int HDR_STAGE_LSB = 20;
  localparam int HDR_STAGE_W   = 8;
  localparam int HDR_IDX_LSB   = 12;
  localparam int HDR_IDX_W     = 8;

  typedef enum logic [3:0] {
    CFG_OP_WRITE = 4'd1,
    CFG_OP_CLEAR = 4'd2
  } cfg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_CLEAR,
    ST_ERR
  } cfg_state_e;

  function automatic logic [HDR_OP_W-1:0] hdr_op(input logic [31:0] w);
    return w[HDR_OP_LSB +: HDR_OP_W];
  endfunction

  function automatic logic [HDR_STAGE_W-1:0] hdr_stage(input logic [31:0] w);
    return w[HDR_STAGE_LSB +: HDR_STAGE_W];
  endfunction

  function automatic logic [HDR_IDX_W-1:0] hdr_idx(input logic [31:0] w);
    return w[HDR_IDX_LSB +: HDR_IDX_W];
  endfunction

endpackage

// File: rtl/type_rule_cfg_ctrl_if.sv
// Config word stream from the host CSR/DMA bridge (valid/ready with last marker).
interface type_rule_cfg_ctrl_if #(
  parameter int CFG_W = 32
);
  logic             cfg_valid;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_last;
  logic             cfg_ready;

  modport master (output cfg_valid, cfg_data, cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, cfg_data, cfg_last, output cfg_ready);
endinterface

// File: rtl/type_rule_cfg_ctrl_assembler.sv
// Collects the payload words of a WRITE command into one type_rule_t.
// Payload arrives LSW first. Only the earlier RULE_WORDS-1 words are stored;
// the final word is taken straight from the bus so the rule is available in
// the same cycle its last beat is accepted.
module type_rule_cfg_ctrl_assembler
  import type_rule_cfg_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [31:0]       word,
  output logic [WCNT_W-1:0] word_cnt,
  output type_rule_t        rule
);

  localparam int HIST_W   = (RULE_WORDS - 1) * 32;
  localparam int TOP_BITS = RULE_BITS - HIST_W;

  logic [HIST_W-1:0] hist_q;
  logic [HIST_W-1:0] hist_nxt;

  generate
    if (RULE_WORDS == 2) begin : g_two_words
      assign hist_nxt = word;
    end else begin : g_many_words
      assign hist_nxt = {word, hist_q[HIST_W-1:32]};
    end
  endgenerate

  // Shift history and count accepted payload words; clear restarts a command.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist_q   <= '0;
      word_cnt <= '0;
    end else if (clear) begin
      hist_q   <= '0;
      word_cnt <= '0;
    end else if (load) begin
      hist_q   <= hist_nxt;
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // Rule as it stands once the word on the bus is included; bits above RULE_BITS drop off.
  assign rule = type_rule_t'({word[TOP_BITS-1:0], hist_q});

endmodule

// File: rtl/type_rule_cfg_ctrl.sv
// Rule-table configuration sequencer.
// Decodes WRITE / CLEAR_ALL commands from the config word stream and pulses
// per-stage, per-rule write enables with the assembled rule data.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for a header word
//   ST_LOAD   | accepting WRITE payload words
//   ST_COMMIT | one-hot write enable + rule on the outputs, done pulse
//   ST_CLEAR  | one stage per cycle, all rules of that stage written to 0
//   ST_ERR    | draining a malformed command up to its last word
module type_rule_cfg_ctrl
  import type_rule_cfg_ctrl_pkg::*;
#(
  parameter int STAGE_NUM = 4,
  parameter int CFG_W     = 32   // only 32 is supported
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  type_rule_cfg_ctrl_if.slave                cfg,
  output logic [STAGE_NUM-1:0][RULE_NUM-1:0] o_rule_wren,
  output type_rule_t                         o_type_rule,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err
);

  localparam int SCNT_W = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;

  cfg_state_e             state_q;
  cfg_state_e             state_nxt;
  logic [SCNT_W-1:0]      clr_cnt_q;
  logic [SCNT_W-1:0]      clr_cnt_nxt;
  logic [HDR_STAGE_W-1:0] stage_q;
  logic [HDR_IDX_W-1:0]   idx_q;

  logic [CFG_W-1:0]       cfg_word;
  logic                   ready_q;
  logic                   accept;
  logic                   is_write;
  logic                   is_clear;
  logic                   stage_ok;
  logic                   idx_ok;
  logic                   final_word;
  logic                   hdr_lat;
  logic                   err_set;
  logic                   err_clr;
  logic                   asm_load;
  logic                   asm_clear;
  logic [WCNT_W-1:0]      word_cnt;
  type_rule_t             asm_rule;

  logic [STAGE_NUM-1:0][RULE_NUM-1:0] wren_d;
  logic                               done_d;
  logic                               ready_d;

  assign cfg_word      = cfg.cfg_data;
  assign cfg.cfg_ready = ready_q;
  assign accept        = cfg.cfg_valid & ready_q;

  assign is_write   = (hdr_op(cfg_word) == CFG_OP_WRITE);
  assign is_clear   = (hdr_op(cfg_word) == CFG_OP_CLEAR);
  assign stage_ok   = (32'(hdr_stage(cfg_word)) < 32'(STAGE_NUM));
  assign idx_ok     = (32'(hdr_idx(cfg_word)) < 32'(RULE_NUM));
  assign final_word = (word_cnt == WCNT_W'(RULE_WORDS - 1));

  type_rule_cfg_ctrl_assembler u_asm (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .clear    (asm_clear),
    .load     (asm_load),
    .word     (cfg_word),
    .word_cnt (word_cnt),
    .rule     (asm_rule)
  );

  // State, clear-stage counter and latched header fields.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      stage_q   <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_nxt;
      clr_cnt_q <= clr_cnt_nxt;
      if (hdr_lat) begin
        stage_q <= hdr_stage(cfg_word);
        idx_q   <= hdr_idx(cfg_word);
      end
    end
  end

  // Next-state decode and per-beat control strobes.
  always_comb begin
    state_nxt   = state_q;
    clr_cnt_nxt = clr_cnt_q;
    hdr_lat     = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;
    asm_load    = 1'b0;
    asm_clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          hdr_lat = 1'b1;
          err_clr = 1'b1;
          if (is_write && !cfg.cfg_last && stage_ok && idx_ok) begin
            state_nxt = ST_LOAD;
            asm_clear = 1'b1;
          end else if (is_clear && cfg.cfg_last) begin
            state_nxt   = ST_CLEAR;
            clr_cnt_nxt = '0;
          end else if (cfg.cfg_last) begin
            // single-beat malformed command: flag it and stay put
            err_set = 1'b1;
          end else begin
            state_nxt = ST_ERR;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          asm_load = 1'b1;
          if (final_word && cfg.cfg_last) begin
            state_nxt = ST_COMMIT;
          end else if (cfg.cfg_last) begin
            state_nxt = ST_IDLE;
            err_set   = 1'b1;
          end else if (final_word) begin
            state_nxt = ST_ERR;
          end
        end
      end
      ST_COMMIT: begin
        state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        if (32'(clr_cnt_q) == STAGE_NUM - 1) begin
          state_nxt = ST_IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt_q + 1'b1;
        end
      end
      ST_ERR: begin
        if (accept && cfg.cfg_last) begin
          state_nxt = ST_IDLE;
          err_set   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write-enable, done and ready values for the coming cycle, driven from the next state
  // so that the registered outputs line up with COMMIT / CLEAR.
  always_comb begin
    wren_d = '0;
    for (int s = 0; s < STAGE_NUM; s++) begin
      for (int r = 0; r < RULE_NUM; r++) begin
        if (state_nxt == ST_COMMIT) begin
          wren_d[s][r] = (32'(stage_q) == s) && (32'(idx_q) == r);
        end else if (state_nxt == ST_CLEAR) begin
          wren_d[s][r] = (32'(clr_cnt_nxt) == s);
        end
      end
    end
    done_d  = (state_nxt == ST_COMMIT) ||
              ((state_nxt == ST_CLEAR) && (32'(clr_cnt_nxt) == STAGE_NUM - 1));
    ready_d = (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD) || (state_nxt == ST_ERR);
  end

  // Registered outputs; rule data holds whenever no write is issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rule_wren <= '0;
      o_type_rule <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      o_rule_wren <= wren_d;
      o_done      <= done_d;
      ready_q     <= ready_d;
      if (state_nxt == ST_COMMIT) begin
        o_type_rule <= asm_rule;
      end else if (state_nxt == ST_CLEAR) begin
        o_type_rule <= '0;
      end
      if (err_set) begin
        o_err <= 1'b1;
      end else if (err_clr) begin
        o_err <= 1'b0;
      end
    end
  end

  assign o_busy = (state_q != ST_IDLE);

endmodule
